d_sram_axi_bridge: RTL and testbench
====================================

# d_sram_axi_bridge

Single-outstanding bridge converting the data cache's SRAM-like master port (cache_data_*) into an AXI3 master (single-beat, 32-bit). Sits directly downstream of the data cache and upstream of the AXI crossbar/arbiter. Accepts one read or write at a time, issues one AXI transaction, and returns a one-cycle data_ok with the read data held stable.

## Interface
- ID, default 4'd1, constant arid/awid/wid value
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  asynchronous active-low reset
- req  in  1  SRAM-like request (from cache_data_req)
- wr  in  1  1 = write, 0 = read
- size  in  2  0 byte, 1 half, 2 word; 3 treated as word
- addr  in  32  byte address
- wdata  in  32  write data, byte lanes already aligned to addr[1:0]
- rdata  out  32  read data, valid when data_ok=1, held until next data_ok
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  one-cycle completion pulse (read or write)
- arvalid/arready  out/in  1/1  read address handshake
- araddr  out  32  latched addr
- arsize  out  3  {1'b0, size_l} (size 3 → 3'd2)
- arid/arlen/arburst/arlock/arcache/arprot  out  4/4/2/2/4/3  ID/0/2'b01/0/0/0
- rvalid/rready  in/out  1/1  read data handshake
- rdata_axi, rresp, rlast, rid  in  32/2/1/4  read beat; rresp/rid ignored
- awvalid/awready  out/in  1/1  write address handshake
- awaddr, awsize  out  32/3  as araddr/arsize
- awid/awlen/awburst/awlock/awcache/awprot  out  4/4/2/2/4/3  same constants as AR
- wvalid/wready  out/in  1/1  write data handshake
- wdata_axi, wstrb, wlast, wid  out  32/4/1/4  latched wdata, strobe, 1, ID
- bvalid/bready  in/out  1/1  write response; bresp/bid ignored

## Operation
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, DONE.
- IDLE: addr_ok = req & resetn (combinational). On addr_ok latch addr, size, wr, wdata; go RD_A if wr=0, else WR_AW.
- RD_A: arvalid=1 until arvalid&arready → RD_D.
- RD_D: rready=1; on rvalid&rready register rdata_axi into rdata → DONE.
- WR_AW: awvalid and wvalid both asserted on entry; each drops independently after its own handshake (aw_done/w_done flags). Both done (incl. same cycle) → WR_B.
- WR_B: bready=1; on bvalid → DONE.
- DONE: data_ok=1 for exactly one cycle; addr_ok=0 → IDLE.
- wstrb from latched size/addr[1:0]: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111. Address not realigned.
- AXI error responses not reported; transaction completes normally.
- Only one transaction in flight; addr_ok=0 in every state except IDLE.

## Timing
- Reset (resetn low, asynchronous): state=IDLE; arvalid, awvalid, wvalid, rready, bready, data_ok, addr_ok = 0; rdata=0; aw_done/w_done=0. Reset mid-transaction drops all valids immediately; no completion pulse.
- AXI outputs are registered or state-decoded; no combinational path from any AXI input to any AXI output.
- Valid signals never deasserted before handshake; araddr/awaddr/wdata_axi/wstrb stable while valid.
- Read, zero-wait slave: accept cycle 0, arvalid cycle 1 (arready), rvalid cycle 2, data_ok cycle 3. Min read latency 3 cycles addr_ok→data_ok.
- Write, zero-wait slave: awvalid+wvalid cycle 1, bvalid cycle 2, data_ok cycle 3.
- Earliest next addr_ok: cycle after data_ok (IDLE).
- rdata unchanged between data_ok pulses, including across writes.

## Test plan
- Read word addr 0x0000_1004, arready=1, rvalid=1 with 0xDEAD_BEEF one cycle after AR → araddr=0x1004, arsize=2, arlen=0, data_ok cycle 3 with rdata=0xDEAD_BEEF.
- Write byte addr 0x0000_2003, wdata=0xAB00_0000; awready after 2 cycles, wready immediately, bvalid 3 cycles later → wstrb=4'b1000, awsize=0, wvalid drops after 1 cycle, awvalid held until its handshake, one data_ok after bvalid.
- Half-word write addr 0x...02 with wready before awready, then reversed order → wstrb=4'b1100 both times, WR_B entered only after both handshakes.
- req held high continuously alternating wr → addr_ok only in IDLE, never two transactions outstanding, data_ok count equals addr_ok count.
- resetn pulled low during RD_D → all valids/readies 0 asynchronously, no data_ok; after release, new read completes normally.
- rresp=2'b10 on a read → data_ok still pulses, rdata captures bus value.

Source files
------------

// File: rtl/d_sram_axi_bridge.sv
// Single-outstanding bridge from the data cache's SRAM-like port to a
// single-beat 32-bit AXI3 master. One request in flight; data_ok pulses once.
module d_sram_axi_bridge #(
  parameter logic [3:0] ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [3:0]  arid,
  output logic [3:0]  arlen,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata_axi,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic [3:0]  rid,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic [3:0]  awid,
  output logic [3:0]  awlen,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata_axi,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic [3:0]  wid,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_D  = 3'd2,
    WR_AW = 3'd3,
    WR_B  = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  // Byte-lane strobe for a latched size/offset; the address itself is never realigned.
  function automatic logic [3:0] lane_strobe(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] s;
    case (sz)
      2'd0:    s = 4'b0001 << off;
      2'd1:    s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Next-state and datapath capture.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    rdata_d   = rdata_q;
    aw_done_d = 1'b0;
    w_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = (size == 2'd3) ? 2'd2 : size;
          state_d = wr ? WR_AW : RD_A;
        end else begin
          state_d = IDLE;
        end
      end
      RD_A: begin
        if (arready) state_d = RD_D;
        else         state_d = RD_A;
      end
      RD_D: begin
        if (rvalid) begin
          rdata_d = rdata_axi;
          state_d = DONE;
        end else begin
          state_d = RD_D;
        end
      end
      WR_AW: begin
        // A done flag stands in for a channel whose handshake already happened.
        if ((aw_done_q | awready) & (w_done_q | wready)) begin
          state_d = WR_B;
        end else begin
          aw_done_d = aw_done_q | awready;
          w_done_d  = w_done_q | wready;
        end
      end
      WR_B: begin
        if (bvalid) state_d = DONE;
        else        state_d = WR_B;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      size_q    <= 2'd0;
      rdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign addr_ok   = (state_q == IDLE) & req & resetn;
  assign data_ok   = (state_q == DONE);
  assign rdata     = rdata_q;

  assign arvalid   = (state_q == RD_A);
  assign araddr    = addr_q;
  assign arsize    = {1'b0, size_q};
  assign arid      = ID;
  assign arlen     = 4'd0;
  assign arburst   = 2'b01;
  assign arlock    = 2'd0;
  assign arcache   = 4'd0;
  assign arprot    = 3'd0;
  assign rready    = (state_q == RD_D);

  assign awvalid   = (state_q == WR_AW) & ~aw_done_q;
  assign awaddr    = addr_q;
  assign awsize    = {1'b0, size_q};
  assign awid      = ID;
  assign awlen     = 4'd0;
  assign awburst   = 2'b01;
  assign awlock    = 2'd0;
  assign awcache   = 4'd0;
  assign awprot    = 3'd0;

  assign wvalid    = (state_q == WR_AW) & ~w_done_q;
  assign wdata_axi = wdata_q;
  assign wstrb     = lane_strobe(size_q, addr_q[1:0]);
  assign wlast     = 1'b1;
  assign wid       = ID;
  assign bready    = (state_q == WR_B);

endmodule

// File: tb/tb_d_sram_axi_bridge.sv
// Self-checking bench for d_sram_axi_bridge: delay-programmable AXI slave,
// transaction-level latency/field model, directed and randomized scenarios.
module tb_d_sram_axi_bridge;

  localparam logic [3:0] ID = 4'd1;

  logic        clk, resetn, req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] araddr, rdata_axi;
  logic [2:0]  arsize, arprot;
  logic [3:0]  arid, arlen, arcache, rid;
  logic [1:0]  arburst, arlock, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [31:0] awaddr, wdata_axi;
  logic [2:0]  awsize, awprot;
  logic [3:0]  awid, awlen, awcache, wstrb, wid;
  logic [1:0]  awburst, awlock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] r_val = 32'd0;
  logic [1:0]  r_resp = 2'd0;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [3:0]  cap_wstrb;
  int ar_hs = 0, aw_hs = 0, w_hs = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0;
  logic [31:0] last_rd = 32'd0;

  d_sram_axi_bridge #(.ID(ID)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arsize(arsize),
    .arid(arid), .arlen(arlen), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .rvalid(rvalid), .rready(rready),
    .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast), .rid(rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awsize(awsize),
    .awid(awid), .awlen(awlen), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .wvalid(wvalid), .wready(wready),
    .wdata_axi(wdata_axi), .wstrb(wstrb), .wlast(wlast), .wid(wid),
    .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Expected strobe: n-byte access occupies the n lanes of its naturally aligned n-byte group.
  function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
    int n;
    int lane;
    n = (sz == 2'd3) ? 4 : (1 << sz);
    lane = int'(a[1:0]) - (int'(a[1:0]) % n);
    return 4'(((1 << n) - 1) << lane);
  endfunction

  function automatic int model_lat(input logic w, input int dar, input int dr,
                                   input int daw, input int dw, input int db);
    return w ? (3 + ((daw > dw) ? daw : dw) + db) : (3 + dar + dr);
  endfunction

  // AXI slave: readies/valids appear after programmed delays; also watches valid stability.
  initial begin
    logic p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    logic [2:0]  p_arsize, p_awsize;
    logic [3:0]  p_wstrb;
    logic r_pend, b_pend, aw_got, w_got;
    int ar_c, r_c, aw_c, w_c, b_c;
    {arready, rvalid, rlast, awready, wready, bvalid} = 6'd0;
    rdata_axi = 32'd0; rresp = 2'd0; rid = 4'd0;
    {p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br} = 10'd0;
    {r_pend, b_pend, aw_got, w_got} = 4'd0;
    {p_araddr, p_awaddr, p_wdata, p_arsize, p_awsize, p_wstrb} = 107'd0;
    ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        {arready, rvalid, rlast, awready, wready, bvalid} = 6'd0;
        {p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br} = 10'd0;
        {r_pend, b_pend, aw_got, w_got} = 4'd0;
        ar_c = 0; aw_c = 0; w_c = 0;
        continue;
      end
      if (p_arv && p_arr) begin
        ar_hs++; cap_araddr = p_araddr; cap_arsize = p_arsize; r_pend = 1'b1; r_c = 0;
      end else if (p_arv) begin
        checks++;
        if (arvalid !== 1'b1 || araddr !== p_araddr || arsize !== p_arsize) begin
          errors++; $display("FAIL ar_stable got v=%b a=%h exp v=1 a=%h", arvalid, araddr, p_araddr);
        end
      end
      if (p_rv && p_rr) r_pend = 1'b0;
      if (p_awv && p_awr) begin
        aw_hs++; aw_hs_cyc = cyc - 1; aw_got = 1'b1; cap_awaddr = p_awaddr; cap_awsize = p_awsize;
      end else if (p_awv) begin
        checks++;
        if (awvalid !== 1'b1 || awaddr !== p_awaddr || awsize !== p_awsize) begin
          errors++; $display("FAIL aw_stable got v=%b a=%h exp v=1 a=%h", awvalid, awaddr, p_awaddr);
        end
      end
      if (p_wv && p_wr) begin
        w_hs++; w_hs_cyc = cyc - 1; w_got = 1'b1; cap_wdata = p_wdata; cap_wstrb = p_wstrb;
      end else if (p_wv) begin
        checks++;
        if (wvalid !== 1'b1 || wdata_axi !== p_wdata || wstrb !== p_wstrb) begin
          errors++; $display("FAIL w_stable got v=%b d=%h s=%b exp v=1 d=%h s=%b", wvalid, wdata_axi, wstrb, p_wdata, p_wstrb);
        end
      end
      if (aw_got && w_got) begin b_pend = 1'b1; b_c = 0; aw_got = 1'b0; w_got = 1'b0; end
      if (p_bv && p_br) b_pend = 1'b0;
      if (rready === 1'b1) begin
        checks++;
        if (!r_pend) begin errors++; $display("FAIL rready_early got 1 exp 0"); end
      end
      if (bready === 1'b1) begin
        checks++;
        if (!b_pend) begin errors++; $display("FAIL bready_before_both got 1 exp 0"); end
      end
      arready = arvalid && (ar_c >= ar_dly);
      if (!arvalid) ar_c = 0; else if (!arready) ar_c++;
      awready = awvalid && (aw_c >= aw_dly);
      if (!awvalid) aw_c = 0; else if (!awready) aw_c++;
      wready = wvalid && (w_c >= w_dly);
      if (!wvalid) w_c = 0; else if (!wready) w_c++;
      if (r_pend && r_c >= r_dly) begin
        rvalid = 1'b1; rdata_axi = r_val; rresp = r_resp; rlast = 1'b1; rid = ID;
      end else begin
        rvalid = 1'b0; rdata_axi = $urandom; rresp = 2'd0; rlast = 1'b0;
        if (r_pend) r_c++;
      end
      if (b_pend && b_c >= b_dly) bvalid = 1'b1;
      else begin bvalid = 1'b0; if (b_pend) b_c++; end
      p_arv = arvalid; p_arr = arready; p_araddr = araddr; p_arsize = arsize;
      p_rv = rvalid; p_rr = rready;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr; p_awsize = awsize;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata_axi; p_wstrb = wstrb;
      p_bv = bvalid; p_br = bready;
    end
  end

  // One complete transaction against the model; c0 returns the acceptance cycle.
  task automatic do_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int dar, input int dr, input int daw,
                        input int dw, input int db, input logic [31:0] rv,
                        input logic [1:0] rr, output int c0);
    int lat;
    int exp_lat;
    int hs0;
    logic [2:0] exp_sz;
    logic [31:0] exp_rd;
    ar_dly = dar; r_dly = dr; aw_dly = daw; w_dly = dw; b_dly = db; r_val = rv; r_resp = rr;
    exp_lat = model_lat(w, dar, dr, daw, dw, db);
    exp_sz = (sz == 2'd3) ? 3'd2 : {1'b0, sz};
    hs0 = ar_hs + aw_hs;
    req = 1'b1; wr = w; size = sz; addr = a; wdata = wd;
    #1;
    checks++;
    if (addr_ok !== 1'b1) begin errors++; $display("FAIL accept got %b exp 1", addr_ok); end
    c0 = cyc;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (data_ok === 1'b1) begin lat = i; break; end
    end
    checks++;
    if (lat != exp_lat) begin errors++; $display("FAIL latency got %0d exp %0d", lat, exp_lat); end
    exp_rd = w ? last_rd : rv;
    checks++;
    if (rdata !== exp_rd) begin errors++; $display("FAIL rdata got %h exp %h", rdata, exp_rd); end
    if (!w) last_rd = rv;
    checks++;
    if (ar_hs + aw_hs != hs0 + 1) begin errors++; $display("FAIL addr_hs_count got %0d exp %0d", ar_hs + aw_hs, hs0 + 1); end
    if (w) begin
      checks++;
      if (cap_awaddr !== a || cap_awsize !== exp_sz || cap_wdata !== wd || cap_wstrb !== model_strb(sz, a)) begin
        errors++;
        $display("FAIL wr_fields got a=%h s=%0d d=%h st=%b exp a=%h s=%0d d=%h st=%b",
                 cap_awaddr, cap_awsize, cap_wdata, cap_wstrb, a, exp_sz, wd, model_strb(sz, a));
      end
    end else begin
      checks++;
      if (cap_araddr !== a || cap_arsize !== exp_sz) begin
        errors++; $display("FAIL rd_fields got a=%h s=%0d exp a=%h s=%0d", cap_araddr, cap_arsize, a, exp_sz);
      end
    end
    @(negedge clk);
    checks++;
    if (data_ok !== 1'b0 || rdata !== exp_rd) begin
      errors++; $display("FAIL pulse_hold got ok=%b rd=%h exp ok=0 rd=%h", data_ok, rdata, exp_rd);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({addr_ok, data_ok, arvalid, awvalid, wvalid, rready, bready} !== 7'd0 || rdata !== 32'd0) begin
      errors++; $display("FAIL reset_state got %b rd=%h exp 0000000 rd=0",
                         {addr_ok, data_ok, arvalid, awvalid, wvalid, rready, bready}, rdata);
    end
    checks++;
    if ({arlen, arburst, arid, arlock, arcache, arprot} !== {4'd0, 2'b01, ID, 2'd0, 4'd0, 3'd0} ||
        {awlen, awburst, awid, awlock, awcache, awprot} !== {4'd0, 2'b01, ID, 2'd0, 4'd0, 3'd0} ||
        {wlast, wid} !== {1'b1, ID}) begin
      errors++; $display("FAIL axi_constants got ar=%h aw=%h w=%h", {arlen, arburst, arid, arlock, arcache, arprot},
                         {awlen, awburst, awid, awlock, awcache, awprot}, {wlast, wid});
    end
    req = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_word();
    int c0;
    do_txn(1'b0, 2'd2, 32'h0000_1004, $urandom, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 2'd0, c0);
  endtask

  task automatic test_write_byte();
    int c0;
    do_txn(1'b1, 2'd0, 32'h0000_2003, 32'hAB00_0000, 0, 0, 2, 0, 3, $urandom, 2'd0, c0);
    checks++;
    if (w_hs_cyc - c0 != 1 || aw_hs_cyc - c0 != 3) begin
      errors++; $display("FAIL wb_hs_cycles got w=%0d aw=%0d exp w=1 aw=3", w_hs_cyc - c0, aw_hs_cyc - c0);
    end
  endtask

  task automatic test_write_half_orders();
    int c0;
    do_txn(1'b1, 2'd1, 32'h0000_3002, $urandom, 0, 0, 2, 0, 0, $urandom, 2'd0, c0);
    checks++;
    if (!(w_hs_cyc < aw_hs_cyc)) begin errors++; $display("FAIL half_w_first got w=%0d aw=%0d", w_hs_cyc, aw_hs_cyc); end
    do_txn(1'b1, 2'd1, 32'h0000_4002, $urandom, 0, 0, 0, 3, 1, $urandom, 2'd0, c0);
    checks++;
    if (!(aw_hs_cyc < w_hs_cyc)) begin errors++; $display("FAIL half_aw_first got w=%0d aw=%0d", w_hs_cyc, aw_hs_cyc); end
  endtask

  task automatic test_rresp_error();
    int c0;
    do_txn(1'b0, 2'd2, $urandom, $urandom, 1, 2, 0, 0, 0, $urandom, 2'b10, c0);
  endtask

  task automatic test_random_single();
    int c0;
    for (int k = 0; k < 24; k++) begin
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)), c0);
    end
  endtask

  task automatic test_reset_mid_read();
    int c0;
    bit seen;
    bit got_rr;
    ar_dly = 0; r_dly = 6; r_val = $urandom; r_resp = 2'd0;
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = $urandom;
    #1;
    checks++;
    if (addr_ok !== 1'b1) begin errors++; $display("FAIL rst_accept got %b exp 1", addr_ok); end
    got_rr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (rready === 1'b1) begin got_rr = 1'b1; break; end
    end
    checks++;
    if (!got_rr) begin errors++; $display("FAIL rst_reach_rd_d got 0 exp 1"); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({addr_ok, data_ok, arvalid, awvalid, wvalid, rready, bready} !== 7'd0 || rdata !== 32'd0) begin
      errors++; $display("FAIL async_reset got %b rd=%h exp 0000000 rd=0",
                         {addr_ok, data_ok, arvalid, awvalid, wvalid, rready, bready}, rdata);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (data_ok !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL rst_no_data_ok got 1 exp 0"); end
    resetn = 1'b1;
    last_rd = 32'd0;
    @(negedge clk);
    do_txn(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, 1, 1, 0, 0, 0, $urandom, 2'd0, c0);
  endtask

  task automatic test_back_to_back();
    logic cur_wr = 1'b0;
    logic busy = 1'b0;
    logic exp_ok;
    logic e_wr = 1'b0;
    logic [1:0] e_sz = 2'd0;
    logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_rd = 32'd0;
    logic [2:0] e_asz;
    int c0 = 0, exp_lat = 0, n_ok = 0, n_done = 0;
    for (int cy = 0; cy < 400; cy++) begin
      req = (cy < 360);
      if (!busy) begin
        wr = cur_wr; size = 2'($urandom_range(0, 3)); addr = $urandom; wdata = $urandom;
      end
      #1;
      exp_ok = !busy && req;
      checks++;
      if (addr_ok !== exp_ok) begin errors++; $display("FAIL b2b_addr_ok cyc %0d got %b exp %b", cyc, addr_ok, exp_ok); end
      if (addr_ok === 1'b1) begin
        busy = 1'b1; n_ok++; c0 = cyc;
        e_wr = wr; e_sz = size; e_addr = addr; e_wdata = wdata; e_rd = $urandom;
        ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3); aw_dly = $urandom_range(0, 3);
        w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
        r_val = e_rd; r_resp = 2'($urandom_range(0, 3));
        exp_lat = model_lat(e_wr, ar_dly, r_dly, aw_dly, w_dly, b_dly);
        cur_wr = ~cur_wr;
      end
      if (data_ok === 1'b1) begin
        e_asz = (e_sz == 2'd3) ? 3'd2 : {1'b0, e_sz};
        checks++;
        if (cyc - c0 != exp_lat) begin errors++; $display("FAIL b2b_latency got %0d exp %0d", cyc - c0, exp_lat); end
        if (!e_wr) last_rd = e_rd;
        checks++;
        if (rdata !== last_rd) begin errors++; $display("FAIL b2b_rdata got %h exp %h", rdata, last_rd); end
        checks++;
        if (e_wr ? (cap_awaddr !== e_addr || cap_awsize !== e_asz || cap_wdata !== e_wdata ||
                    cap_wstrb !== model_strb(e_sz, e_addr))
                 : (cap_araddr !== e_addr || cap_arsize !== e_asz)) begin
          errors++; $display("FAIL b2b_fields wr=%b got a=%h st=%b exp a=%h st=%b", e_wr,
                             e_wr ? cap_awaddr : cap_araddr, cap_wstrb, e_addr, model_strb(e_sz, e_addr));
        end
        busy = 1'b0; n_done++;
      end
      @(negedge clk);
    end
    checks++;
    if (n_ok != n_done || n_ok < 20 || busy) begin
      errors++; $display("FAIL b2b_counts got ok=%0d done=%0d exp equal and >=20", n_ok, n_done);
    end
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'd0; wdata = 32'd0;
    @(negedge clk);
    test_reset();
    test_read_word();
    test_write_byte();
    test_write_half_orders();
    test_rresp_error();
    test_random_single();
    test_reset_mid_read();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
